// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the architectural PC, reads a word-addressed
// instruction memory with one-cycle latency, and hands {ins, pc} to execute
// through a valid/ready handshake. Fetch stops permanently on the HALT opcode
// until the next reset.
module fetch_unit #(
    parameter int          IMEM_AW  = 8,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic               clk,
    input  logic               rst,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic               imem_rd,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        ins,
    output logic [31:0]        pc,
    output logic               ins_valid,
    input  logic               ins_ready,
    input  logic [31:0]        nextpc,
    output logic               halted,
    output logic [31:0]        retired_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ISSUE = 3'd3,
        ST_HALT  = 3'd4
    } state_e;

    localparam logic [5:0] HALT_OPCODE = 6'd63;

    // True when the instruction word carries the HALT opcode.
    function automatic logic is_halt_op(input logic [31:0] word);
        return (word[31:26] == HALT_OPCODE);
    endfunction

    state_e      state_q;
    state_e      state_d;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] ins_q;
    logic [31:0] ins_d;
    logic [31:0] retired_cnt_q;
    logic [31:0] retired_cnt_d;

    logic        accept_s;
    logic        in_wait_s;
    logic        imem_rd_s;
    logic        ins_valid_s;
    logic        halted_s;

    // A transfer to execute happens only while presenting an instruction.
    assign accept_s  = (state_q == ST_ISSUE) && ins_ready;
    assign in_wait_s = (state_q == ST_WAIT);

    // State register; reset wins over any concurrent handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode for the fetch sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (is_halt_op(imem_rdata)) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (ins_ready) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                // Unreachable encodings recover through a clean restart.
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control outputs decoded purely from the registered state.
    always_comb begin
        imem_rd_s   = 1'b0;
        ins_valid_s = 1'b0;
        halted_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                imem_rd_s = 1'b0;
            end
            ST_FETCH: begin
                imem_rd_s = 1'b1;
            end
            ST_WAIT: begin
                imem_rd_s = 1'b0;
            end
            ST_ISSUE: begin
                ins_valid_s = 1'b1;
            end
            ST_HALT: begin
                halted_s = 1'b1;
            end
            default: begin
                imem_rd_s   = 1'b0;
                ins_valid_s = 1'b0;
                halted_s    = 1'b0;
            end
        endcase
    end

    // Next PC and retire count: only a completed handshake moves them.
    always_comb begin
        pc_d          = pc_q;
        retired_cnt_d = retired_cnt_q;
        if (accept_s) begin
            pc_d          = nextpc;
            retired_cnt_d = retired_cnt_q + 32'd1;
        end else begin
            pc_d          = pc_q;
            retired_cnt_d = retired_cnt_q;
        end
    end

    // Instruction capture: the memory word is valid only during WAIT.
    always_comb begin
        ins_d = ins_q;
        if (in_wait_s) begin
            ins_d = imem_rdata;
        end else begin
            ins_d = ins_q;
        end
    end

    // Datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            ins_q         <= 32'd0;
            retired_cnt_q <= 32'd0;
        end else begin
            pc_q          <= pc_d;
            ins_q         <= ins_d;
            retired_cnt_q <= retired_cnt_d;
        end
    end

    // Upper PC bits alias silently onto the small memory.
    assign imem_addr   = pc_q[IMEM_AW-1:0];
    assign imem_rd     = imem_rd_s;
    assign ins         = ins_q;
    assign pc          = pc_q;
    assign ins_valid   = ins_valid_s;
    assign halted      = halted_s;
    assign retired_cnt = retired_cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit with a behavioural
// one-cycle synchronous instruction memory.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic [7:0]  imem_addr;
    logic        imem_rd;
    logic [31:0] imem_rdata;
    logic [31:0] ins;
    logic [31:0] pc;
    logic        ins_valid;
    logic        ins_ready;
    logic [31:0] nextpc;
    logic        halted;
    logic [31:0] retired_cnt;

    int checks;
    int failures;

    logic [31:0] mem [256];

    fetch_unit #(.IMEM_AW(8), .RESET_PC(32'd0)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_addr   (imem_addr),
        .imem_rd     (imem_rd),
        .imem_rdata  (imem_rdata),
        .ins         (ins),
        .pc          (pc),
        .ins_valid   (ins_valid),
        .ins_ready   (ins_ready),
        .nextpc      (nextpc),
        .halted      (halted),
        .retired_cnt (retired_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle synchronous instruction memory.
    always @(posedge clk) begin
        if (imem_rd) imem_rdata <= mem[imem_addr];
    end

    typedef struct {
        logic        rst;
        logic        rdy;
        logic [31:0] npc;
        logic        valid;
        logic        halted;
        logic        rd;
        logic [7:0]  addr;
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs [21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic rdy, input logic [31:0] npc);
        rst       = r;
        ins_ready = rdy;
        nextpc    = npc;
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        imem_rdata = 32'd0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0000_1000 | i;
        drive(1'b1, 1'b0, 32'd0);

        //            rst   rdy   nextpc          valid halt  rd    addr   pc             ins           cnt
        vecs[0]  = '{1'b1, 1'b0, 32'd0,         1'b0, 1'b0, 1'b0, 8'h00, 32'h0,         32'h0,        32'd0};
        vecs[1]  = '{1'b1, 1'b0, 32'd0,         1'b0, 1'b0, 1'b0, 8'h00, 32'h0,         32'h0,        32'd0};
        vecs[2]  = '{1'b0, 1'b0, 32'd0,         1'b0, 1'b0, 1'b1, 8'h00, 32'h0,         32'h0,        32'd0};
        vecs[3]  = '{1'b0, 1'b0, 32'd0,         1'b0, 1'b0, 1'b0, 8'h00, 32'h0,         32'h0,        32'd0};
        vecs[4]  = '{1'b0, 1'b0, 32'd0,         1'b1, 1'b0, 1'b0, 8'h00, 32'h0,         32'h1000,     32'd0};
        vecs[5]  = '{1'b0, 1'b1, 32'd1,         1'b0, 1'b0, 1'b1, 8'h01, 32'h1,         32'h1000,     32'd1};
        vecs[6]  = '{1'b0, 1'b1, 32'h55,        1'b0, 1'b0, 1'b0, 8'h01, 32'h1,         32'h1000,     32'd1};
        vecs[7]  = '{1'b0, 1'b1, 32'h55,        1'b1, 1'b0, 1'b0, 8'h01, 32'h1,         32'h1001,     32'd1};
        vecs[8]  = '{1'b0, 1'b1, 32'd2,         1'b0, 1'b0, 1'b1, 8'h02, 32'h2,         32'h1001,     32'd2};
        vecs[9]  = '{1'b0, 1'b0, 32'd0,         1'b0, 1'b0, 1'b0, 8'h02, 32'h2,         32'h1001,     32'd2};
        vecs[10] = '{1'b0, 1'b0, 32'd0,         1'b1, 1'b0, 1'b0, 8'h02, 32'h2,         32'h1002,     32'd2};
        vecs[11] = '{1'b0, 1'b1, 32'h105,       1'b0, 1'b0, 1'b1, 8'h05, 32'h105,       32'h1002,     32'd3};
        vecs[12] = '{1'b0, 1'b0, 32'd0,         1'b0, 1'b0, 1'b0, 8'h05, 32'h105,       32'h1002,     32'd3};
        vecs[13] = '{1'b0, 1'b0, 32'd0,         1'b1, 1'b0, 1'b0, 8'h05, 32'h105,       32'h1005,     32'd3};
        vecs[14] = '{1'b0, 1'b0, 32'h77,        1'b1, 1'b0, 1'b0, 8'h05, 32'h105,       32'h1005,     32'd3};
        vecs[15] = '{1'b0, 1'b1, 32'hFFFFFFFF,  1'b0, 1'b0, 1'b1, 8'hFF, 32'hFFFFFFFF,  32'h1005,     32'd4};
        vecs[16] = '{1'b0, 1'b0, 32'd0,         1'b0, 1'b0, 1'b0, 8'hFF, 32'hFFFFFFFF,  32'h1005,     32'd4};
        vecs[17] = '{1'b0, 1'b0, 32'd0,         1'b1, 1'b0, 1'b0, 8'hFF, 32'hFFFFFFFF,  32'h10FF,     32'd4};
        vecs[18] = '{1'b0, 1'b1, 32'd0,         1'b0, 1'b0, 1'b1, 8'h00, 32'h0,         32'h10FF,     32'd5};
        vecs[19] = '{1'b0, 1'b0, 32'd0,         1'b0, 1'b0, 1'b0, 8'h00, 32'h0,         32'h10FF,     32'd5};
        vecs[20] = '{1'b0, 1'b0, 32'd0,         1'b1, 1'b0, 1'b0, 8'h00, 32'h0,         32'h1000,     32'd5};

        // Reset, sequential fetch, branch, backpressure tick and PC wrap.
        for (int i = 0; i < 21; i++) begin
            drive(vecs[i].rst, vecs[i].rdy, vecs[i].npc);
            step();
            check($sformatf("v%0d_valid", i), {31'd0, ins_valid}, {31'd0, vecs[i].valid});
            check($sformatf("v%0d_halted", i), {31'd0, halted}, {31'd0, vecs[i].halted});
            check($sformatf("v%0d_rd", i), {31'd0, imem_rd}, {31'd0, vecs[i].rd});
            check($sformatf("v%0d_addr", i), {24'd0, imem_addr}, {24'd0, vecs[i].addr});
            check($sformatf("v%0d_pc", i), pc, vecs[i].pc);
            check($sformatf("v%0d_ins", i), ins, vecs[i].ins);
            check($sformatf("v%0d_cnt", i), retired_cnt, vecs[i].cnt);
        end

        // Backpressure: five stalled cycles in ISSUE at pc=0, count 5.
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 1'b0, 32'hDEAD);
            step();
            check($sformatf("bp%0d_valid", k), {31'd0, ins_valid}, 32'd1);
            check($sformatf("bp%0d_pc", k), pc, 32'h0);
            check($sformatf("bp%0d_ins", k), ins, 32'h1000);
            check($sformatf("bp%0d_rd", k), {31'd0, imem_rd}, 32'd0);
            check($sformatf("bp%0d_cnt", k), retired_cnt, 32'd5);
        end
        drive(1'b0, 1'b1, 32'd1);
        step();
        check("bp_accept_cnt", retired_cnt, 32'd6);
        check("bp_accept_pc", pc, 32'h1);
        check("bp_accept_valid", {31'd0, ins_valid}, 32'd0);
        drive(1'b0, 1'b0, 32'd0);
        step();
        check("bp_single_inc", retired_cnt, 32'd6);

        // Reset in ISSUE together with a handshake: reset must win.
        step();
        check("t6_pre_valid", {31'd0, ins_valid}, 32'd1);
        check("t6_pre_pc", pc, 32'h1);
        drive(1'b1, 1'b1, 32'd9);
        step();
        check("t6_valid", {31'd0, ins_valid}, 32'd0);
        check("t6_pc", pc, 32'h0);
        check("t6_cnt", retired_cnt, 32'd0);
        check("t6_ins", ins, 32'h0);

        // Halt: imem[1] is HALT; only pc=0 retires, then fetch stops.
        mem[1] = 32'hFC00_0000;
        drive(1'b0, 1'b0, 32'd0);
        step(); step(); step();
        check("t5_first_valid", {31'd0, ins_valid}, 32'd1);
        check("t5_first_pc", pc, 32'h0);
        drive(1'b0, 1'b1, 32'd1);
        step();
        check("t5_fetch_halted", {31'd0, halted}, 32'd0);
        step();
        check("t5_wait_valid", {31'd0, ins_valid}, 32'd0);
        drive(1'b0, 1'b1, 32'd7);
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("t5_h%0d_halted", k), {31'd0, halted}, 32'd1);
            check($sformatf("t5_h%0d_valid", k), {31'd0, ins_valid}, 32'd0);
            check($sformatf("t5_h%0d_rd", k), {31'd0, imem_rd}, 32'd0);
            check($sformatf("t5_h%0d_pc", k), pc, 32'h1);
            check($sformatf("t5_h%0d_cnt", k), retired_cnt, 32'd1);
        end
        drive(1'b1, 1'b0, 32'd0);
        step();
        check("t5_rst_halted", {31'd0, halted}, 32'd0);
        check("t5_rst_pc", pc, 32'h0);
        drive(1'b0, 1'b0, 32'd0);
        step(); step(); step();
        check("t5_restart_valid", {31'd0, ins_valid}, 32'd1);
        check("t5_restart_pc", pc, 32'h0);
        check("t5_restart_ins", ins, 32'h1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
